// File: rtl/axis_frame_monitor.sv
// axis_frame_monitor: AXI-Stream sink with programmable backpressure,
// per-frame length/TKEEP/checksum checks and saturating statistics.
module axis_frame_monitor #(
    parameter int          W         = 32,
    parameter int          KW        = W/8,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [W-1:0]     s_axis_tdata,
    input  logic [KW-1:0]    s_axis_tkeep,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic [1:0]       cfg_ready_mode,
    input  logic [7:0]       cfg_period,
    input  logic [15:0]      cfg_min_len,
    input  logic [15:0]      cfg_max_len,
    input  logic             clr_stats,
    output logic [15:0]      word_count,
    output logic [15:0]      byte_count,
    output logic [CNT_W-1:0] frame_count,
    output logic [15:0]      last_len,
    output logic [15:0]      last_bytes,
    output logic [W-1:0]     last_csum,
    output logic             frame_done,
    output logic [CNT_W-1:0] err_runt_count,
    output logic [CNT_W-1:0] err_giant_count,
    output logic [CNT_W-1:0] err_keep_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        RDY_ALWAYS = 2'd0,
        RDY_NEVER  = 2'd1,
        RDY_LFSR   = 2'd2,
        RDY_PERIOD = 2'd3
    } rdy_mode_e;

    function automatic logic [15:0] popcnt(input logic [KW-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + 16'(k[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [15:0]   lfsr;
    logic [7:0]    pcnt;
    logic [W-1:0]  csum;
    logic          keep_bad;

    logic          beat, eof;
    logic [15:0]   pc, len_nxt, bytes_nxt;
    logic [16:0]   bsum;
    logic [KW-1:0] keep_p1;
    logic          last_keep_ok, mid_keep_ok;
    logic          runt, giant, keep_err;

    // Next-state values for the frame counters and the end-of-frame checks
    always_comb begin
        beat         = s_axis_tvalid & s_axis_tready;
        eof          = beat & s_axis_tlast;
        pc           = popcnt(s_axis_tkeep);
        len_nxt      = (&word_count) ? word_count : word_count + 16'd1;
        bsum         = {1'b0, byte_count} + {1'b0, pc};
        bytes_nxt    = bsum[16] ? 16'hFFFF : bsum[15:0];
        // contiguous-from-bit-0 masks are exactly those where keep & (keep+1) == 0
        keep_p1      = s_axis_tkeep + KW'(1);
        last_keep_ok = (s_axis_tkeep != '0) && ((s_axis_tkeep & keep_p1) == '0);
        mid_keep_ok  = &s_axis_tkeep;
        runt         = len_nxt < cfg_min_len;
        giant        = len_nxt > cfg_max_len;
        keep_err     = keep_bad | ~last_keep_ok;
    end

    // Backpressure generator: free-running LFSR and period counter, registered tready
    always_ff @(posedge clk) begin
        if (areset) begin
            lfsr          <= LFSR_SEED;
            pcnt          <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pcnt <= (pcnt >= cfg_period) ? 8'd0 : pcnt + 8'd1;
            case (rdy_mode_e'(cfg_ready_mode))
                RDY_ALWAYS: s_axis_tready <= 1'b1;
                RDY_NEVER:  s_axis_tready <= 1'b0;
                RDY_LFSR:   s_axis_tready <= lfsr[0];
                RDY_PERIOD: s_axis_tready <= (pcnt == 8'd0);
                default:    s_axis_tready <= 1'b0;
            endcase
        end
    end

    // Frame state: running counts/checksum, latched on TLAST into last_*
    always_ff @(posedge clk) begin
        if (areset) begin
            word_count <= '0;
            byte_count <= '0;
            csum       <= '0;
            keep_bad   <= 1'b0;
            last_len   <= '0;
            last_bytes <= '0;
            last_csum  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (eof) begin
                last_len   <= len_nxt;
                last_bytes <= bytes_nxt;
                last_csum  <= csum ^ s_axis_tdata;
                frame_done <= 1'b1;
                word_count <= '0;
                byte_count <= '0;
                csum       <= '0;
                keep_bad   <= 1'b0;
            end else if (beat) begin
                word_count <= len_nxt;
                byte_count <= bytes_nxt;
                csum       <= csum ^ s_axis_tdata;
                if (!mid_keep_ok) keep_bad <= 1'b1;
            end
        end
    end

    // Statistics: saturating counters; clr_stats overrides any same-cycle update
    always_ff @(posedge clk) begin
        if (areset || clr_stats) begin
            frame_count     <= '0;
            err_runt_count  <= '0;
            err_giant_count <= '0;
            err_keep_count  <= '0;
            stall_count     <= '0;
            err_sticky      <= 1'b0;
        end else begin
            if (s_axis_tvalid && !s_axis_tready) stall_count <= sat_inc(stall_count);
            if (eof) begin
                frame_count <= sat_inc(frame_count);
                if (runt)     err_runt_count  <= sat_inc(err_runt_count);
                if (giant)    err_giant_count <= sat_inc(err_giant_count);
                if (keep_err) err_keep_count  <= sat_inc(err_keep_count);
                if (runt || giant || keep_err) err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_monitor.sv
// Scoreboard bench for axis_frame_monitor: expected frame results are queued
// at issue time and popped by a monitor on each frame_done pulse.
module tb_axis_frame_monitor;
    localparam int W     = 32;
    localparam int KW    = W/8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             areset;
    logic [W-1:0]     s_axis_tdata;
    logic [KW-1:0]    s_axis_tkeep;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [1:0]       cfg_ready_mode;
    logic [7:0]       cfg_period;
    logic [15:0]      cfg_min_len;
    logic [15:0]      cfg_max_len;
    logic             clr_stats;
    logic [15:0]      word_count, byte_count, last_len, last_bytes;
    logic [CNT_W-1:0] frame_count, err_runt_count, err_giant_count, err_keep_count, stall_count;
    logic [W-1:0]     last_csum;
    logic             frame_done, err_sticky;

    always #5 clk = ~clk;

    axis_frame_monitor #(.W(W), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .cfg_ready_mode(cfg_ready_mode), .cfg_period(cfg_period),
        .cfg_min_len(cfg_min_len), .cfg_max_len(cfg_max_len),
        .clr_stats(clr_stats),
        .word_count(word_count), .byte_count(byte_count),
        .frame_count(frame_count), .last_len(last_len),
        .last_bytes(last_bytes), .last_csum(last_csum),
        .frame_done(frame_done),
        .err_runt_count(err_runt_count), .err_giant_count(err_giant_count),
        .err_keep_count(err_keep_count), .stall_count(stall_count),
        .err_sticky(err_sticky)
    );

    typedef struct {
        logic [15:0]  len;
        logic [15:0]  bytes;
        logic [W-1:0] csum;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] len, input logic [15:0] bytes, input logic [W-1:0] csum);
        exp_t e;
        e.len = len; e.bytes = bytes; e.csum = csum;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one beat from a negedge; return at the negedge after its handshake
    task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
        int t;
        t = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 64'(t), 64'd0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Monitor: every frame_done must match the oldest queued expectation
    always @(negedge clk) begin
        if (frame_done) begin
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_frame_done", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("last_len",   64'(last_len),   64'(mon_e.len));
                check("last_bytes", 64'(last_bytes), 64'(mon_e.bytes));
                check("last_csum",  64'(last_csum),  64'(mon_e.csum));
            end
        end
    end

    initial begin
        int acc, hs;
        areset = 1'b1; clr_stats = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        cfg_ready_mode = 2'd0; cfg_period = 8'd0; cfg_min_len = 16'd1; cfg_max_len = 16'd16;
        idle(3);
        check("rst_tready",      64'(s_axis_tready), 64'd0);
        check("rst_frame_count", 64'(frame_count),   64'd0);
        check("rst_last_len",    64'(last_len),      64'd0);
        check("rst_frame_done",  64'(frame_done),    64'd0);
        check("rst_sticky",      64'(err_sticky),    64'd0);
        areset = 1'b0;
        idle(2);
        check("tready_mode0", 64'(s_axis_tready), 64'd1);

        // three 4-beat frames, data 1..4, full keep
        for (int f = 0; f < 3; f++) begin
            push(16'd4, 16'd16, 32'h4);
            for (int b = 1; b <= 4; b++) send(W'(b), 4'hF, b == 4);
        end
        check("t1_frame_count", 64'(frame_count), 64'd3);
        check("t1_stall",       64'(stall_count), 64'd0);
        check("t1_word_count",  64'(word_count),  64'd0);

        // single-beat frame
        push(16'd1, 16'd2, 32'hA5);
        send(32'hA5, 4'h3, 1'b1);
        check("t2_frame_count", 64'(frame_count),    64'd4);
        check("t2_keep_err",    64'(err_keep_count), 64'd0);
        check("t2_runt",        64'(err_runt_count), 64'd0);
        check("t2_sticky",      64'(err_sticky),     64'd0);

        // runt then giant then legal length
        cfg_min_len = 16'd4; cfg_max_len = 16'd8;
        push(16'd2, 16'd8, 32'h3);
        send(32'd1, 4'hF, 1'b0); send(32'd2, 4'hF, 1'b1);
        check("t3_runt", 64'(err_runt_count), 64'd1);
        push(16'd10, 16'd40, 32'hB);
        for (int b = 1; b <= 10; b++) send(W'(b), 4'hF, b == 10);
        check("t3_giant",  64'(err_giant_count), 64'd1);
        check("t3_sticky", 64'(err_sticky),      64'd1);
        push(16'd5, 16'd20, 32'h1);
        for (int b = 1; b <= 5; b++) send(W'(b), 4'hF, b == 5);
        check("t3_runt_after",  64'(err_runt_count),  64'd1);
        check("t3_giant_after", 64'(err_giant_count), 64'd1);
        check("t3_frame_count", 64'(frame_count),     64'd7);

        // illegal keep mid-frame and on the last beat: one error per frame
        cfg_min_len = 16'd1;
        push(16'd3, 16'd9, 32'h77);
        send(32'h11, 4'hF, 1'b0);
        send(32'h22, 4'h7, 1'b0);
        check("t4_word_count", 64'(word_count), 64'd2);
        check("t4_byte_count", 64'(byte_count), 64'd7);
        send(32'h44, 4'h5, 1'b1);
        check("t4_keep_err",    64'(err_keep_count), 64'd1);
        check("t4_frame_count", 64'(frame_count),    64'd8);

        // periodic ready, tvalid held 40 cycles
        cfg_max_len = 16'd16; cfg_ready_mode = 2'd3; cfg_period = 8'd3;
        idle(4);
        push(16'd10, 16'd40, 32'hB);
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            s_axis_tvalid = 1'b1; s_axis_tkeep = 4'hF;
            s_axis_tdata  = W'(acc + 1);
            s_axis_tlast  = (acc == 9);
            hs = int'(s_axis_tready);
            @(negedge clk);
            acc += hs;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("t5_beats", 64'(acc),         64'd10);
        check("t5_stall", 64'(stall_count), 64'd30);

        // never ready for 16 cycles
        cfg_ready_mode = 2'd1;
        idle(2);
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'hBAD; s_axis_tlast = 1'b0;
            acc += int'(s_axis_tready);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        check("t5_never_beats", 64'(acc),         64'd0);
        check("t5_never_stall", 64'(stall_count), 64'd46);
        cfg_ready_mode = 2'd0;
        idle(2);

        // clr_stats on the TLAST beat
        push(16'd2, 16'd8, 32'h300);
        send(32'h100, 4'hF, 1'b0);
        clr_stats = 1'b1;
        send(32'h200, 4'hF, 1'b1);
        clr_stats = 1'b0;
        check("t6_frame_count", 64'(frame_count),    64'd0);
        check("t6_stall",       64'(stall_count),    64'd0);
        check("t6_sticky",      64'(err_sticky),     64'd0);
        check("t6_keep_err",    64'(err_keep_count), 64'd0);

        // reset mid-frame discards the partial frame
        send(32'hDEAD, 4'hF, 1'b0);
        send(32'hBEEF, 4'hF, 1'b0);
        areset = 1'b1;
        @(negedge clk);
        check("t7_word_count", 64'(word_count),    64'd0);
        check("t7_byte_count", 64'(byte_count),    64'd0);
        check("t7_last_len",   64'(last_len),      64'd0);
        check("t7_last_csum",  64'(last_csum),     64'd0);
        check("t7_tready",     64'(s_axis_tready), 64'd0);
        areset = 1'b0;
        idle(2);
        push(16'd3, 16'd12, 32'h7);
        for (int b = 0; b < 3; b++) send(32'h7, 4'hF, b == 2);
        check("t7_frame_count", 64'(frame_count), 64'd1);

        // pseudo-random backpressure keeps data intact
        cfg_ready_mode = 2'd2;
        push(16'd4, 16'd16, 32'h1111);
        send(32'h1, 4'hF, 1'b0); send(32'h10, 4'hF, 1'b0);
        send(32'h100, 4'hF, 1'b0); send(32'h1000, 4'hF, 1'b1);
        check("t8_frame_count", 64'(frame_count), 64'd2);

        idle(3);
        check("queue_empty", 64'(q.size()), 64'd0);
        check("done_pulses", 64'(n_done),   64'd12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_frame_monitor.md
Name: axis_frame_monitor

Overview:
Parametrised AXI-Stream sink and frame checker. It is the successor to the always-ready bring-up sink and terminates an M_AXIS output (FIFO, parser, loopback).
It adds programmable backpressure (always, never, pseudo-random, periodic), TKEEP-aware byte counting, per-frame length and TKEEP checks, an XOR checksum, and saturating statistics for software or ILA readout.

Parameters:
W, 32, TDATA width in bits; multiple of 8, 8..512
KW, W/8, TKEEP width; derived, do not override
CNT_W, 32, width of the statistics counters
LFSR_SEED, 16'hACE1, LFSR value at reset; must be non-zero

Ports:
clk  in  1  clock; all logic is on the rising edge
areset  in  1  synchronous, active-high reset
s_axis_tdata  in  W  stream data
s_axis_tkeep  in  KW  byte qualifiers
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  registered ready
s_axis_tlast  in  1  end of frame
cfg_ready_mode  in  2  0=always, 1=never, 2=LFSR random, 3=periodic
cfg_period  in  8  mode 3: ready for 1 cycle out of every cfg_period+1
cfg_min_len  in  16  minimum legal frame length in beats
cfg_max_len  in  16  maximum legal frame length in beats
clr_stats  in  1  single-cycle pulse; clears statistics
word_count  out  16  beats accepted in the current frame
byte_count  out  16  bytes accepted in the current frame
frame_count  out  CNT_W  completed frames
last_len  out  16  beat count of the most recent frame
last_bytes  out  16  byte count of the most recent frame
last_csum  out  W  XOR of all tdata beats of the most recent frame
frame_done  out  1  1-cycle pulse, one cycle after the TLAST handshake
err_runt_count  out  CNT_W  frames with length < cfg_min_len
err_giant_count  out  CNT_W  frames with length > cfg_max_len
err_keep_count  out  CNT_W  frames with an illegal TKEEP
stall_count  out  CNT_W  cycles with tvalid=1 and tready=0
err_sticky  out  1  set by any error; cleared only by clr_stats or areset

Behaviour:
- Accepted beat (beat) = s_axis_tvalid & s_axis_tready. Only beats update frame state.
- Reset: every output 0, s_axis_tready 0, LFSR = LFSR_SEED, period counter 0, running checksum 0. s_axis_tready takes its mode value from the first cycle after reset.
- tready is registered and computed from the current mode and its generator. It may drop while tvalid=1; that is legal for a sink.
  - Mode 0: tready=1.
  - Mode 1: tready=0.
  - Mode 2: tready = LFSR bit 0. The LFSR is a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle in every mode.
  - Mode 3: a period counter runs 0..cfg_period, then wraps to 0. tready=1 when the counter is 0. cfg_period=0 means always ready.
- Per beat:
  - word_count += 1 and byte_count += popcount(tkeep). Both saturate at 16'hFFFF.
  - Running checksum ^= tdata.
- TKEEP legality:
  - A non-last beat must be all ones.
  - A last beat must be non-zero and contiguous from bit 0 (for example 0001, 0011, 0111, 1111).
  - A violation sets a frame-local keep_bad flag.
- Frame end (beat with tlast=1), registered on the next edge:
  - len = word_count+1 (saturating) is latched into last_len.
  - byte_count plus this beat's bytes is latched into last_bytes.
  - running checksum ^ tdata is latched into last_csum.
  - frame_count += 1.
  - frame_done=1 for exactly one cycle.
  - word_count, byte_count, running checksum and keep_bad return to 0.
- Error classification at frame end, at most one increment per counter per frame:
  - runt if len < cfg_min_len.
  - giant if len > cfg_max_len.
  - keep error if keep_bad, or this beat's tkeep is illegal.
  - Any error also sets err_sticky.
- A single-beat frame (tlast on the first beat) has len=1. It passes the length checks when cfg_min_len ≤ 1.
- stall_count increments on every cycle with tvalid=1 and tready=0, including in mode 1.
- Every CNT_W counter saturates at all ones and never wraps.
- clr_stats:
  - Clears frame_count, the three error counters, stall_count and err_sticky.
  - Does not clear the in-progress frame state or the last_* registers.
  - If clr_stats coincides with a frame-end update: last_* still latch and frame_done still pulses, but the counters end at 0 (clear wins).
- areset mid-frame discards the partial frame with no counter or error update.
- cfg_* inputs are sampled every cycle. A change mid-frame takes effect immediately; the length checks use the values present at the TLAST beat.

Test Plan:
- Mode 0, W=32, three frames of 4 beats with data 1,2,3,4 and tkeep=F → frame_count=3, last_len=4, last_bytes=16, last_csum=0x4, frame_done pulses 3 times, stall_count=0.
- Mode 0, single beat with tlast=1, tkeep=0x3, data 0xA5 → last_len=1, last_bytes=2, last_csum=0xA5, no errors with cfg_min_len=1.
- cfg_min_len=4, cfg_max_len=8, frames of 2 and 10 beats → err_runt_count=1, err_giant_count=1, err_sticky=1; a following 5-beat frame adds no errors.
- Mid-frame tkeep=0x7, then a last beat with tkeep=0x5 → err_keep_count=1 (once per frame); last_bytes counts the popcounts.
- Mode 3 with cfg_period=3 and tvalid held high for 40 cycles → tready high 1 cycle in 4, 10 beats accepted, stall_count=30. Mode 1 for 16 cycles → 0 beats, stall_count +16.
- clr_stats coinciding with a tlast beat → frame_count=0 and last_* updated. areset mid-frame → all outputs 0 and the next frame counts from 1.
